prio_scan_encoder: RTL and testbench
====================================

PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input vector width, legal range 2..256.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 emits set bits lowest index first, 1 emits highest index first.
REQ-003 SHALL have derived localparam IDX_W, equal to max(1, $clog2(WIDTH)), not overridable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: capture enable; en=0 blocks new captures only.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can capture in_data.
REQ-009 SHALL have port in_data, input, WIDTH bits: multi-hot request vector.
REQ-010 SHALL have port out_valid, output, 1 bit: out_idx, out_last, out_none and out_par are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the current beat.
REQ-012 SHALL have port out_idx, output, IDX_W bits: index of the current set bit.
REQ-013 SHALL have port out_last, output, 1 bit: current beat is the final beat of this vector.
REQ-014 SHALL have port out_none, output, 1 bit: the captured vector was all-zero.
REQ-015 SHALL have port out_par, output, 1 bit: even-parity bit over out_idx (see Configuration).

Function
REQ-016 SHALL implement a two-state FSM, IDLE and SCAN, with a WIDTH-bit pending register.
REQ-017 SHALL drive in_ready = en AND (state==IDLE OR (out_valid AND out_ready AND out_last)).
REQ-018 SHALL, on in_valid AND in_ready at edge T, load pending<=in_data, enter SCAN, and assert out_valid from T+1.
REQ-019 SHALL present, in SCAN, out_idx = index of the lowest set pending bit (MSB_FIRST=0) or the highest (MSB_FIRST=1).
REQ-020 SHALL assert out_last when exactly one pending bit is set.
REQ-021 SHALL, on out_valid AND out_ready, clear the emitted bit; if out_last, return to IDLE, unless a same-cycle capture re-enters SCAN (back-to-back, no bubble).
REQ-022 SHALL hold out_idx, out_last, out_none and out_par stable while out_valid=1 and out_ready=0.
REQ-023 SHALL emit, for an all-zero capture, exactly one beat with out_none=1, out_idx=0, out_last=1.
REQ-024 SHALL emit exactly popcount(in_data) beats per non-zero vector, in strictly monotonic index order.
REQ-025 SHALL let a scan in progress continue to completion when en is deasserted.
REQ-026 SHALL drive out_valid=0, out_idx=0, out_last=0, out_none=0 and out_par=0 in IDLE.

Reset
REQ-027 SHALL, on rst=1 asynchronously, set state=IDLE, pending=0 and every output to 0 (in_ready follows REQ-017).
REQ-028 SHALL abort any scan in progress on reset mid-scan, with no further beats for that vector after release.

Configuration
REQ-029 SHALL drive out_par = XOR-reduce(out_idx) while out_valid=1 when macro PRIO_SCAN_PARITY_EN is defined.
REQ-030 SHALL keep the out_par port present but tie it constant 0, with no parity logic, when PRIO_SCAN_PARITY_EN is undefined.

Structure
REQ-031 SHALL place the FSM state enum and an idx_width function (the IDX_W rule) in shared package prio_enc_pkg.
REQ-032 SHALL use one combinational sub-module, prio_idx, parametrised by WIDTH and MSB_FIRST, returning index and found flag for a vector.

Verification
REQ-033 SHALL check: WIDTH=8, MSB_FIRST=0, en=1, in_data=8'b1010_0100, out_ready=1 -> idx 2,5,7 on consecutive cycles, out_last only on 7.
REQ-034 SHALL check: same vector with MSB_FIRST=1 -> idx 7,5,2; with PRIO_SCAN_PARITY_EN, out_par=1,0,1.
REQ-035 SHALL check: in_data=0 -> one beat with out_none=1, out_idx=0, out_last=1, then IDLE.
REQ-036 SHALL check: out_ready held 0 for 3 cycles mid-scan -> outputs stable, no beat lost; a second vector offered on the last handshake is captured with no idle cycle.
REQ-037 SHALL check: en=0 with in_valid=1 -> in_ready=0 and no capture; en dropped mid-scan -> remaining beats still emitted.
REQ-038 SHALL check: rst pulsed after the first beat of 8'hFF -> all outputs 0 immediately; after release, no stale beats and in_ready=en.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types for the priority scan encoder: FSM state encoding and the index-width rule.
package prio_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic int idx_width(input int width);
      return ($clog2(width) > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/prio_idx.sv
// Combinational priority pick: index of the lowest (or highest when MSB_FIRST) set bit, plus a found flag.
module prio_idx
   import prio_enc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan toward the preferred end so the last hit seen is the winning one.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
               idx   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
               idx   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/prio_scan_encoder.sv
// Captures a multi-hot vector and emits one registered beat per set bit (one beat, out_none, if zero); first beat one cycle after capture, beats held under out_ready=0.
// Build option PRIO_SCAN_PARITY_EN adds even parity over out_idx on out_par; otherwise out_par is tied 0.
module prio_scan_encoder
   import prio_enc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none,
   output logic             out_par
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             out_none_q, out_none_d;

   logic [IDX_W-1:0] nxt_idx;
   logic             nxt_found;
   logic             fire;
   logic             cap;

   assign fire     = out_valid_q & out_ready;
   assign in_ready = en & ((state_q == IDLE) | (fire & out_last_q));
   assign cap      = in_valid & in_ready;

   // Outputs are registered, so the picker looks at the pending value the next cycle will hold.
   prio_idx #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_idx (
      .vec   (pending_d),
      .idx   (nxt_idx),
      .found (nxt_found)
   );

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      out_none_d = out_none_q;
      if (cap) begin
         state_d    = SCAN;
         pending_d  = in_data;
         out_none_d = (in_data == '0);
      end else if (fire) begin
         pending_d = pending_q & ~(ONE << out_idx_q);
         if (out_last_q) begin
            state_d = IDLE;
         end
      end

      out_valid_d = (state_d == SCAN);
      out_idx_d   = '0;
      out_last_d  = 1'b0;
      if (state_d == SCAN) begin
         out_idx_d  = nxt_idx;
         out_last_d = out_none_d | (nxt_found & ((pending_d & (pending_d - ONE)) == '0));
      end else begin
         out_none_d = 1'b0;
      end
   end

`ifdef PRIO_SCAN_PARITY_EN
   logic out_par_q, out_par_d;

   assign out_par_d = out_valid_d & (^out_idx_d);
   assign out_par   = out_par_q;
`else
   assign out_par = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_none_q  <= 1'b0;
`ifdef PRIO_SCAN_PARITY_EN
         out_par_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_none_q  <= out_none_d;
`ifdef PRIO_SCAN_PARITY_EN
         out_par_q   <= out_par_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_none  = out_none_q;

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Bench for prio_scan_encoder: LSB-first and MSB-first instances share stimulus; directed table, hand sequences, then random traffic against a beat-queue model.
module tb_prio_scan_encoder;

   localparam bit T = 1'b1;
   localparam bit F = 1'b0;
`ifdef PRIO_SCAN_PARITY_EN
   localparam int PAR_ON = 1;
`else
   localparam int PAR_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       rdy0, vld0, last0, none0, par0;
   logic       rdy1, vld1, last1, none1, par1;
   logic [2:0] idx0, idx1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .out_valid(vld0), .out_ready(out_ready), .out_idx(idx0), .out_last(last0),
      .out_none(none0), .out_par(par0)
   );

   prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .out_valid(vld1), .out_ready(out_ready), .out_idx(idx1), .out_last(last1),
      .out_none(none1), .out_par(par1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int epar(input int idx);
      return ($countones(idx) % 2) * PAR_ON;
   endfunction

   // Reference model: the list of beats still owed, per emission order.
   typedef struct {
      int idx;
      bit last;
      bit none;
   } beat_t;

   beat_t      q0[$];
   beat_t      q1[$];
   bit         m_fire, m_cap, m_busy, m_rdy;
   logic [7:0] m_data;

   task automatic push_vec(input logic [7:0] v);
      int n;
      int k;
      n = $countones(v);
      if (v == 8'h00) begin
         q0.push_back('{0, T, T});
         q1.push_back('{0, T, T});
      end else begin
         k = 0;
         for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
               k++;
               q0.push_back('{i, (k == n), F});
            end
         end
         k = 0;
         for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
               k++;
               q1.push_back('{i, (k == n), F});
            end
         end
      end
   endtask

   always @(negedge clk) begin
      m_fire = F;
      m_cap  = F;
      if (rst) begin
         q0.delete();
         q1.delete();
         chk("mon_rst_vld", int'({vld0, vld1}), 0);
         chk("mon_rst_outs", int'({idx0, idx1, last0, none0, par0, last1, none1, par1}), 0);
         chk("mon_rst_rdy", int'(rdy0), int'(en));
      end else begin
         m_busy = (q0.size() != 0);
         m_rdy  = en && (!m_busy || (out_ready && q0.size() == 1));
         chk("mon_vld0", int'(vld0), int'(m_busy));
         chk("mon_vld1", int'(vld1), int'(m_busy));
         chk("mon_rdy0", int'(rdy0), int'(m_rdy));
         chk("mon_rdy1", int'(rdy1), int'(m_rdy));
         if (m_busy && q1.size() != 0) begin
            chk("mon_idx0", int'(idx0), q0[0].idx);
            chk("mon_last0", int'(last0), int'(q0[0].last));
            chk("mon_none0", int'(none0), int'(q0[0].none));
            chk("mon_par0", int'(par0), epar(q0[0].idx));
            chk("mon_idx1", int'(idx1), q1[0].idx);
            chk("mon_last1", int'(last1), int'(q1[0].last));
            chk("mon_none1", int'(none1), int'(q1[0].none));
            chk("mon_par1", int'(par1), epar(q1[0].idx));
         end else begin
            chk("mon_idle_outs", int'({idx0, idx1, last0, none0, par0, last1, none1, par1}), 0);
         end
         m_fire = m_busy && out_ready;
         m_cap  = in_valid && m_rdy;
         m_data = in_data;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (m_fire) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
         if (m_cap) push_vec(m_data);
      end
   end

   typedef struct {
      bit         en;
      bit         iv;
      logic [7:0] d;
      bit         ordy;
      bit         e_rdy;
      bit         e_vld;
      int         e_i0;
      int         e_i1;
      bit         e_last;
      bit         e_none;
   } row_t;

   row_t tbl[16];
   int   beats;

   initial begin
      //            en iv data   ordy  rdy vld i0 i1 last none
      tbl[0]  = '{T, T, 8'hA4, T,   T, F, 0, 0, F, F};
      tbl[1]  = '{T, F, 8'h00, T,   F, T, 2, 7, F, F};
      tbl[2]  = '{T, F, 8'h00, T,   F, T, 5, 5, F, F};
      tbl[3]  = '{T, T, 8'h00, T,   T, T, 7, 2, T, F};
      tbl[4]  = '{T, F, 8'h00, T,   T, T, 0, 0, T, T};
      tbl[5]  = '{T, F, 8'h00, T,   T, F, 0, 0, F, F};
      tbl[6]  = '{T, T, 8'h85, T,   T, F, 0, 0, F, F};
      tbl[7]  = '{T, F, 8'h00, T,   F, T, 0, 7, F, F};
      tbl[8]  = '{T, F, 8'h00, F,   F, T, 2, 2, F, F};
      tbl[9]  = '{T, F, 8'h00, F,   F, T, 2, 2, F, F};
      tbl[10] = '{T, F, 8'h00, F,   F, T, 2, 2, F, F};
      tbl[11] = '{T, F, 8'h00, T,   F, T, 2, 2, F, F};
      tbl[12] = '{T, T, 8'h0A, T,   T, T, 7, 0, T, F};
      tbl[13] = '{T, F, 8'h00, T,   F, T, 1, 3, F, F};
      tbl[14] = '{T, F, 8'h00, T,   T, T, 3, 1, T, F};
      tbl[15] = '{T, F, 8'h00, T,   T, F, 0, 0, F, F};

      // Reset state
      @(negedge clk);
      chk("reset_vld", int'({vld0, vld1}), 0);
      chk("reset_outs", int'({idx0, last0, none0, par0, idx1, last1, none1, par1}), 0);
      chk("reset_rdy", int'(rdy0), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Directed cycle table
      for (int r = 0; r < 16; r++) begin
         @(posedge clk); #1;
         en        = tbl[r].en;
         in_valid  = tbl[r].iv;
         in_data   = tbl[r].d;
         out_ready = tbl[r].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_rdy", r), int'(rdy0), int'(tbl[r].e_rdy));
         chk($sformatf("tbl%0d_vld", r), int'(vld0), int'(tbl[r].e_vld));
         chk($sformatf("tbl%0d_idx0", r), int'(idx0), tbl[r].e_i0);
         chk($sformatf("tbl%0d_idx1", r), int'(idx1), tbl[r].e_i1);
         chk($sformatf("tbl%0d_last", r), int'(last0), int'(tbl[r].e_last));
         chk($sformatf("tbl%0d_none", r), int'(none0), int'(tbl[r].e_none));
         chk($sformatf("tbl%0d_par1", r), int'(par1), tbl[r].e_vld ? epar(tbl[r].e_i1) : 0);
      end

      // en low blocks capture
      @(posedge clk); #1;
      en = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
      @(negedge clk);
      chk("en0_rdy", int'(rdy0), 0);
      repeat (2) begin
         @(negedge clk);
         chk("en0_no_capture", int'(vld0), 0);
      end

      // en dropped mid-scan: remaining beats still come out
      @(posedge clk); #1;
      en = 1'b1; in_valid = 1'b1; in_data = 8'h07;
      @(negedge clk);
      chk("en1_rdy", int'(rdy0), 1);
      @(posedge clk); #1;
      en = 1'b0; in_valid = 1'b0;
      beats = 0;
      repeat (8) begin
         @(negedge clk);
         if (vld0 && out_ready) beats++;
      end
      chk("en_drop_beats", beats, 3);

      // Reset after the first beat of 0xFF
      @(posedge clk); #1;
      en = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_first_vld", int'(vld0), 1);
      chk("rstmid_first_idx", int'(idx0), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid_async_vld", int'({vld0, vld1}), 0);
      chk("rstmid_async_outs", int'({idx0, last0, none0, par0, idx1, last1, none1, par1}), 0);
      chk("rstmid_async_rdy", int'(rdy0), int'(en));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("rstmid_no_stale", int'(vld0), 0);
         chk("rstmid_rdy", int'(rdy0), 1);
      end

      // Random traffic against the model
      repeat (3000) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 7) != 0);
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("drain_vld", int'({vld0, vld1}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
